// File: rtl/dpram_port_arbiter.sv
// Front-end for a true dual-port RAM. After reset it clears every location, then
// serves two req/gnt requesters, splitting same-address write collisions by rotating priority.
module dpram_port_arbiter #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     a_req,
  input  logic                     b_req,
  input  logic                     a_rw,
  input  logic                     b_rw,
  input  logic [$clog2(DEPTH)-1:0] a_addr,
  input  logic [$clog2(DEPTH)-1:0] b_addr,
  input  logic [DATA_W-1:0]        a_wdata,
  input  logic [DATA_W-1:0]        b_wdata,
  output logic                     a_gnt,
  output logic                     b_gnt,
  output logic                     a_rvalid,
  output logic                     b_rvalid,
  output logic [DATA_W-1:0]        a_rdata,
  output logic [DATA_W-1:0]        b_rdata,
  output logic                     init_done,
  output logic [7:0]               wr_conflicts,
  output logic                     ram_a_rw,
  output logic                     ram_b_rw,
  output logic [$clog2(DEPTH)-1:0] ram_a_w_addr,
  output logic [$clog2(DEPTH)-1:0] ram_b_w_addr,
  output logic [$clog2(DEPTH)-1:0] ram_a_r_addr,
  output logic [$clog2(DEPTH)-1:0] ram_b_r_addr,
  output logic [DATA_W-1:0]        ram_a_indata,
  output logic [DATA_W-1:0]        ram_b_indata,
  input  logic [DATA_W-1:0]        ram_a_outdata,
  input  logic [DATA_W-1:0]        ram_b_outdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int KW = (DEPTH > 2) ? $clog2(DEPTH / 2) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(DEPTH / 2 - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t        state;
  logic [KW-1:0] k;
  logic          prio_b;
  logic [7:0]    conflicts;
  logic          a_vld_p1;
  logic          b_vld_p1;
  logic          run;
  logic          conflict_p0;
  logic [AW-1:0] init_even;
  logic [AW-1:0] init_odd;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign run       = (state == S_RUN);
  assign init_even = AW'({k, 1'b0});
  assign init_odd  = AW'({k, 1'b1});

  // Stage p0: arbitration and RAM port drive, all combinational from the request fields
  always_comb begin
    conflict_p0 = run && a_req && b_req && a_rw && b_rw && (a_addr == b_addr);
    a_gnt       = run && a_req && !(conflict_p0 && prio_b);
    b_gnt       = run && b_req && !(conflict_p0 && !prio_b);
    if (run) begin
      // A losing or idle port still presents its address as a harmless read
      ram_a_rw     = a_gnt && a_rw;
      ram_a_w_addr = a_addr;
      ram_a_r_addr = a_addr;
      ram_a_indata = a_wdata;
      ram_b_rw     = b_gnt && b_rw;
      ram_b_w_addr = b_addr;
      ram_b_r_addr = b_addr;
      ram_b_indata = b_wdata;
    end else begin
      ram_a_rw     = 1'b1;
      ram_a_w_addr = init_even;
      ram_a_r_addr = init_even;
      ram_a_indata = '0;
      ram_b_rw     = 1'b1;
      ram_b_w_addr = init_odd;
      ram_b_r_addr = init_odd;
      ram_b_indata = '0;
    end
  end

  // Stage p1: sweep/run sequencing, priority rotation, collision count, read strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_INIT;
      k         <= '0;
      prio_b    <= 1'b0;
      conflicts <= '0;
      a_vld_p1  <= 1'b0;
      b_vld_p1  <= 1'b0;
    end else begin
      a_vld_p1 <= a_gnt && !a_rw;
      b_vld_p1 <= b_gnt && !b_rw;
      case (state)
        S_INIT: begin
          k <= k + 1'b1;
          if (k == K_LAST) state <= S_RUN;
        end
        S_RUN: begin
          if (conflict_p0) begin
            prio_b    <= !prio_b;
            conflicts <= sat_inc8(conflicts);
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

  assign init_done    = run;
  assign wr_conflicts = conflicts;
  assign a_rvalid     = a_vld_p1;
  assign b_rvalid     = b_vld_p1;
  assign a_rdata      = ram_a_outdata;
  assign b_rdata      = ram_b_outdata;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Bench for dpram_port_arbiter: RAM environment, behavioural reference model checked every
// cycle, directed sequences with literal expectations, then randomized traffic.
module tb_dpram_port_arbiter;
  localparam int DW  = 4;
  localparam int DEP = 8;
  localparam int AW  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_req = 1'b0, b_req = 1'b0, a_rw = 1'b0, b_rw = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid, init_done, ram_a_rw, ram_b_rw;
  logic [DW-1:0] a_rdata, b_rdata, ram_a_indata, ram_b_indata;
  logic [DW-1:0] ram_a_outdata = '0, ram_b_outdata = '0;
  logic [7:0]    wr_conflicts;
  logic [AW-1:0] ram_a_w_addr, ram_b_w_addr, ram_a_r_addr, ram_b_r_addr;

  int checks = 0;
  int failures = 0;

  // RAM environment starts with non-zero contents so a missed sweep location shows up
  logic [DW-1:0] ram [DEP] = '{default: 4'hF};
  logic [DW-1:0] ref_mem [DEP] = '{default: 4'h0};

  int            m_k = 0;
  bit            m_run = 1'b0;
  bit            m_prio_b = 1'b0;
  int            m_conf = 0;
  bit            ea_vld = 1'b0, eb_vld = 1'b0;
  logic [DW-1:0] ea_dat = '0, eb_dat = '0;

  dpram_port_arbiter #(.DATA_W(DW), .DEPTH(DEP)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .b_req(b_req), .a_rw(a_rw), .b_rw(b_rw),
    .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .a_rdata(a_rdata), .b_rdata(b_rdata), .init_done(init_done),
    .wr_conflicts(wr_conflicts), .ram_a_rw(ram_a_rw), .ram_b_rw(ram_b_rw),
    .ram_a_w_addr(ram_a_w_addr), .ram_b_w_addr(ram_b_w_addr),
    .ram_a_r_addr(ram_a_r_addr), .ram_b_r_addr(ram_b_r_addr),
    .ram_a_indata(ram_a_indata), .ram_b_indata(ram_b_indata),
    .ram_a_outdata(ram_a_outdata), .ram_b_outdata(ram_b_outdata)
  );

  always #5 clk = ~clk;

  // Read-first true dual-port RAM with registered outputs
  always @(posedge clk) begin
    if (ram_a_rw) ram[ram_a_w_addr] <= ram_a_indata;
    if (ram_b_rw) ram[ram_b_w_addr] <= ram_b_indata;
    ram_a_outdata <= ram[ram_a_r_addr];
    ram_b_outdata <= ram[ram_b_r_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_sweep(input int k);
    check("init_a_gnt", 32'(a_gnt), 0);
    check("init_b_gnt", 32'(b_gnt), 0);
    check("init_ram_a_rw", 32'(ram_a_rw), 1);
    check("init_ram_b_rw", 32'(ram_b_rw), 1);
    check("init_ram_a_w_addr", 32'(ram_a_w_addr), 32'(2 * k));
    check("init_ram_b_w_addr", 32'(ram_b_w_addr), 32'(2 * k + 1));
    check("init_ram_a_indata", 32'(ram_a_indata), 0);
    check("init_ram_b_indata", 32'(ram_b_indata), 0);
  endtask

  // Reference model: evaluated once per cycle at the falling edge, inputs are stable then
  always @(negedge clk) begin
    bit cf, ga, gb;
    if (rst) begin
      m_k = 0; m_run = 1'b0; m_prio_b = 1'b0; m_conf = 0; ea_vld = 1'b0; eb_vld = 1'b0;
      check("rst_a_rvalid", 32'(a_rvalid), 0);
      check("rst_b_rvalid", 32'(b_rvalid), 0);
      check("rst_init_done", 32'(init_done), 0);
      check("rst_wr_conflicts", 32'(wr_conflicts), 0);
      check_sweep(0);
      ref_mem[0] = '0;
      ref_mem[1] = '0;
    end else begin
      check("a_rvalid", 32'(a_rvalid), 32'(ea_vld));
      check("b_rvalid", 32'(b_rvalid), 32'(eb_vld));
      if (ea_vld) check("a_rdata", 32'(a_rdata), 32'(ea_dat));
      if (eb_vld) check("b_rdata", 32'(b_rdata), 32'(eb_dat));
      check("init_done", 32'(init_done), 32'(m_run));
      check("wr_conflicts", 32'(wr_conflicts), 32'(m_conf));
      if (!m_run) begin
        check_sweep(m_k);
        ref_mem[2 * m_k] = '0;
        ref_mem[2 * m_k + 1] = '0;
        ea_vld = 1'b0;
        eb_vld = 1'b0;
        m_k++;
        if (m_k == DEP / 2) m_run = 1'b1;
      end else begin
        cf = a_req && b_req && a_rw && b_rw && (a_addr == b_addr);
        ga = a_req && !(cf && m_prio_b);
        gb = b_req && !(cf && !m_prio_b);
        check("a_gnt", 32'(a_gnt), 32'(ga));
        check("b_gnt", 32'(b_gnt), 32'(gb));
        check("ram_a_rw", 32'(ram_a_rw), 32'(ga && a_rw));
        check("ram_b_rw", 32'(ram_b_rw), 32'(gb && b_rw));
        check("ram_a_r_addr", 32'(ram_a_r_addr), 32'(a_addr));
        check("ram_b_r_addr", 32'(ram_b_r_addr), 32'(b_addr));
        if (ga && a_rw) begin
          check("ram_a_w_addr", 32'(ram_a_w_addr), 32'(a_addr));
          check("ram_a_indata", 32'(ram_a_indata), 32'(a_wdata));
        end
        if (gb && b_rw) begin
          check("ram_b_w_addr", 32'(ram_b_w_addr), 32'(b_addr));
          check("ram_b_indata", 32'(ram_b_indata), 32'(b_wdata));
        end
        ea_vld = ga && !a_rw;
        eb_vld = gb && !b_rw;
        ea_dat = ref_mem[a_addr];
        eb_dat = ref_mem[b_addr];
        if (ga && a_rw) ref_mem[a_addr] = a_wdata;
        if (gb && b_rw) ref_mem[b_addr] = b_wdata;
        if (cf) begin
          m_prio_b = !m_prio_b;
          if (m_conf < 255) m_conf++;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic req, input logic rw, input int addr, input int data);
    a_req = req; a_rw = rw; a_addr = AW'(addr); a_wdata = DW'(data);
  endtask

  task automatic set_b(input logic req, input logic rw, input int addr, input int data);
    b_req = req; b_rw = rw; b_addr = AW'(addr); b_wdata = DW'(data);
  endtask

  task automatic idle();
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  initial begin
    logic ag, bg;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("lit_init_done", 32'(init_done), 1);
    check("lit_conf0", 32'(wr_conflicts), 0);

    set_a(1, 0, 5, 0); #1;
    check("lit_first_gnt", 32'(a_gnt), 1);
    cyc(); idle(); #1;
    check("lit_rd5_vld", 32'(a_rvalid), 1);
    check("lit_rd5_data", 32'(a_rdata), 0);

    set_a(1, 1, 3, 'hA); cyc(); set_a(1, 0, 3, 0); cyc(); idle(); #1;
    check("lit_rd3_vld", 32'(a_rvalid), 1);
    check("lit_rd3_data", 32'(a_rdata), 'hA);
    check("lit_rd3_b_vld", 32'(b_rvalid), 0);

    set_a(1, 1, 2, 5); set_b(1, 1, 2, 9); #1;
    check("lit_col1_a_gnt", 32'(a_gnt), 1);
    check("lit_col1_b_gnt", 32'(b_gnt), 0);
    cyc(); a_req = 1'b0; #1;
    check("lit_col1_b_late", 32'(b_gnt), 1);
    check("lit_col1_count", 32'(wr_conflicts), 1);
    cyc(); b_req = 1'b0; set_a(1, 0, 2, 0); cyc(); a_req = 1'b0; #1;
    check("lit_col1_rd", 32'(a_rdata), 9);
    set_a(1, 1, 2, 1); set_b(1, 1, 2, 7); #1;
    check("lit_col2_b_gnt", 32'(b_gnt), 1);
    check("lit_col2_a_gnt", 32'(a_gnt), 0);
    cyc(); b_req = 1'b0; #1;
    check("lit_col2_a_late", 32'(a_gnt), 1);
    check("lit_col2_count", 32'(wr_conflicts), 2);
    cyc(); a_req = 1'b0;

    set_a(1, 1, 6, 'hC); set_b(1, 0, 6, 0); #1;
    check("lit_rw_a_gnt", 32'(a_gnt), 1);
    check("lit_rw_b_gnt", 32'(b_gnt), 1);
    cyc(); a_req = 1'b0; set_b(1, 0, 6, 0); #1;
    check("lit_rw_old", 32'(b_rdata), 0);
    cyc(); idle(); #1;
    check("lit_rw_new", 32'(b_rdata), 'hC);

    set_a(1, 1, 1, 3); set_b(1, 1, 7, 'hE); cyc();
    set_a(1, 0, 1, 0); set_b(1, 0, 7, 0); cyc(); idle(); #1;
    check("lit_dual_a", 32'(a_rdata), 3);
    check("lit_dual_b", 32'(b_rdata), 'hE);
    check("lit_dual_bvld", 32'(b_rvalid), 1);

    set_a(1, 1, 4, 1); set_b(1, 1, 4, 2);
    repeat (300) cyc();
    idle(); #1;
    check("lit_sat", 32'(wr_conflicts), 255);

    set_a(1, 1, 3, 'hB); cyc(); set_a(1, 0, 3, 0); cyc(); idle(); #1;
    check("lit_pend_vld", 32'(a_rvalid), 1);
    rst = 1'b1; #1;
    check("lit_rst_vld", 32'(a_rvalid), 0);
    check("lit_rst_done", 32'(init_done), 0);
    cyc(); rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("lit_resweep_done", 32'(init_done), 1);
    set_a(1, 0, 3, 0); cyc(); idle(); #1;
    check("lit_resweep_vld", 32'(a_rvalid), 1);
    check("lit_resweep_data", 32'(a_rdata), 0);

    // Randomized traffic; request fields are held until granted
    for (int i = 0; i < 3000; i++) begin
      #2;
      ag = a_gnt;
      bg = b_gnt;
      cyc();
      if (!a_req || ag)
        set_a($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 1) != 0) ? $urandom_range(0, 1) : $urandom_range(0, 7),
              $urandom_range(0, 15));
      if (!b_req || bg)
        set_b($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 1) != 0) ? $urandom_range(0, 1) : $urandom_range(0, 7),
              $urandom_range(0, 15));
      if (i == 1500) begin
        rst = 1'b1;
        cyc();
        rst = 1'b0;
      end
    end
    idle();
    cyc();
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
